// File: rtl/hdc_pkg.sv
// +--------------------------------------------------------------------------+
// | hdc_pkg : shared sizes and FSM state encoding for the HDC search blocks  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package hdc_pkg;

  localparam int N_CLASSES = 8;
  localparam int N_FRAMES  = 3;
  localparam int FRAME_W   = 64;
  localparam int DIST_W    = $clog2(N_FRAMES * FRAME_W + 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Index width that stays at least one bit for degenerate single-entry sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hvec_popcount.sv
// +--------------------------------------------------------------------------+
// | hvec_popcount : combinational population count of one frame             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hvec_popcount #(
  parameter  int W     = 64,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CNT_W'(vec_i[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hvec_assoc_search.sv
// +--------------------------------------------------------------------------+
// | hvec_assoc_search : min-Hamming class search, optional ASSOC_REJECT_EN   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hvec_assoc_search #(
  parameter  int N_CLASSES = hdc_pkg::N_CLASSES,
  parameter  int N_FRAMES  = hdc_pkg::N_FRAMES,
  parameter  int FRAME_W   = hdc_pkg::FRAME_W,
  localparam int DIST_W    = $clog2(N_FRAMES * FRAME_W + 1),
  localparam int CID_W     = hdc_pkg::idx_w(N_CLASSES),
  localparam int FID_W     = hdc_pkg::idx_w(N_FRAMES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [FRAME_W-1:0] q_frame,
  output logic [CID_W-1:0]   cls_frame_id,
  output logic [FID_W-1:0]   cls_frame_index,
  input  logic [FRAME_W-1:0] cls_frame_in,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CID_W-1:0]   result_class,
  output logic [DIST_W-1:0]  result_dist,
  output logic               busy
`ifdef ASSOC_REJECT_EN
  ,
  input  logic [DIST_W-1:0]  reject_thr,
  output logic               result_reject
`endif
);

  import hdc_pkg::*;

  localparam int PC_W = $clog2(FRAME_W + 1);
  localparam logic [FID_W-1:0] LAST_F = FID_W'(N_FRAMES - 1);
  localparam logic [CID_W-1:0] LAST_C = CID_W'(N_CLASSES - 1);

  state_e              state_q, state_d;
  logic [FID_W-1:0]    fcnt_q, fcnt_d;
  logic [CID_W-1:0]    ccnt_q, ccnt_d;
  logic [DIST_W-1:0]   acc_q, acc_d;
  logic [DIST_W-1:0]   best_dist_q, best_dist_d;
  logic [CID_W-1:0]    best_class_q, best_class_d;
  logic [FRAME_W-1:0]  qbuf_q [N_FRAMES];

  logic [PC_W-1:0]     frame_dist;
  logic [DIST_W-1:0]   dist_total;
  logic                q_fire;
  logic                last_frame;
  logic                last_class;
  logic                take_best;

  assign q_fire     = q_valid && q_ready;
  assign last_frame = (fcnt_q == LAST_F);
  assign last_class = (ccnt_q == LAST_C);
  assign dist_total = acc_q + DIST_W'(frame_dist);
  // Strict less-than: on ties the earlier (lower-index) class is kept.
  assign take_best  = (ccnt_q == '0) || (dist_total < best_dist_q);

  hvec_popcount #(
    .W (FRAME_W)
  ) u_popcount (
    .vec_i (qbuf_q[fcnt_q] ^ cls_frame_in),
    .cnt_o (frame_dist)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (q_fire && last_frame) state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (last_frame && last_class) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    q_ready         = (state_q == ST_LOAD) && rst_n;
    result_valid    = (state_q == ST_DONE);
    busy            = (state_q == ST_SEARCH) || (state_q == ST_DONE);
    cls_frame_id    = '0;
    cls_frame_index = '0;
    if (state_q == ST_SEARCH) begin
      cls_frame_id    = ccnt_q;
      cls_frame_index = fcnt_q;
    end
  end

  assign result_class = best_class_q;
  assign result_dist  = best_dist_q;

`ifdef ASSOC_REJECT_EN
  assign result_reject = result_valid && (best_dist_q > reject_thr);
`endif

  // Counters and distance accumulation.
  always_comb begin
    fcnt_d       = fcnt_q;
    ccnt_d       = ccnt_q;
    acc_d        = acc_q;
    best_dist_d  = best_dist_q;
    best_class_d = best_class_q;
    case (state_q)
      ST_LOAD: begin
        if (q_fire) begin
          if (last_frame) begin
            fcnt_d = '0;
            ccnt_d = '0;
            acc_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      ST_SEARCH: begin
        if (last_frame) begin
          fcnt_d = '0;
          acc_d  = '0;
          ccnt_d = last_class ? '0 : ccnt_q + 1'b1;
          if (take_best) begin
            best_dist_d  = dist_total;
            best_class_d = ccnt_q;
          end
        end else begin
          fcnt_d = fcnt_q + 1'b1;
          acc_d  = dist_total;
        end
      end
      ST_DONE: begin
        if (result_ready) fcnt_d = '0;
      end
      default: begin
        fcnt_d = '0;
        ccnt_d = '0;
        acc_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q       <= '0;
      ccnt_q       <= '0;
      acc_q        <= '0;
      best_dist_q  <= '0;
      best_class_q <= '0;
    end else begin
      fcnt_q       <= fcnt_d;
      ccnt_q       <= ccnt_d;
      acc_q        <= acc_d;
      best_dist_q  <= best_dist_d;
      best_class_q <= best_class_d;
    end
  end

  // Query buffer carries no reset; its contents only matter after a full load.
  always_ff @(posedge clk) begin
    if (q_fire) qbuf_q[fcnt_q] <= q_frame;
  end

endmodule

`default_nettype wire

// File: tb/tb_hvec_assoc_search.sv
// +--------------------------------------------------------------------------+
// | tb_hvec_assoc_search : directed self-checking bench for the class search |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hvec_assoc_search;

  import hdc_pkg::*;

  localparam int CID_W = idx_w(N_CLASSES);
  localparam int FID_W = idx_w(N_FRAMES);
  localparam int VEC_W = N_FRAMES * FRAME_W;
  localparam logic [FRAME_W-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               q_valid;
  logic               q_ready;
  logic [FRAME_W-1:0] q_frame;
  logic [CID_W-1:0]   cls_frame_id;
  logic [FID_W-1:0]   cls_frame_index;
  logic [FRAME_W-1:0] cls_frame_in;
  logic               result_valid;
  logic               result_ready;
  logic [CID_W-1:0]   result_class;
  logic [DIST_W-1:0]  result_dist;
  logic               busy;
`ifdef ASSOC_REJECT_EN
  logic [DIST_W-1:0]  reject_thr;
  logic               result_reject;
`endif

  logic [FRAME_W-1:0] cls_mem [N_CLASSES][N_FRAMES];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign cls_frame_in = cls_mem[cls_frame_id][cls_frame_index];

  hvec_assoc_search dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .q_valid         (q_valid),
    .q_ready         (q_ready),
    .q_frame         (q_frame),
    .cls_frame_id    (cls_frame_id),
    .cls_frame_index (cls_frame_index),
    .cls_frame_in    (cls_frame_in),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_class    (result_class),
    .result_dist     (result_dist),
    .busy            (busy)
`ifdef ASSOC_REJECT_EN
    ,
    .reject_thr      (reject_thr),
    .result_reject   (result_reject)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] cls_vec(input int k);
    logic [VEC_W-1:0] v;
    for (int f = 0; f < N_FRAMES; f++) v[f*FRAME_W +: FRAME_W] = cls_mem[k][f];
    return v;
  endfunction

  task automatic set_cls(input int k, input logic [VEC_W-1:0] v);
    for (int f = 0; f < N_FRAMES; f++) cls_mem[k][f] = v[f*FRAME_W +: FRAME_W];
  endtask

  // Presents all frames back to back, then keeps q_valid high with junk data.
  task automatic send_frames(input logic [VEC_W-1:0] v);
    for (int f = 0; f < N_FRAMES; f++) begin
      @(negedge clk);
      q_valid = 1'b1;
      q_frame = v[f*FRAME_W +: FRAME_W];
      @(posedge clk);
    end
    @(negedge clk);
    q_frame = JUNK;
  endtask

  // Returns posedges from the first accepting edge (counted as 1) to result_valid.
  task automatic run_query(input logic [VEC_W-1:0] v, output int lat);
    lat = N_FRAMES;
    send_frames(v);
    while (!result_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ld_valid", result_valid, 0);
    check("ld_qready", q_ready, 1);
    check("ld_busy", busy, 0);
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  initial begin
    logic [VEC_W-1:0] qv;
    int lat;
    bit found;

    for (int k = 0; k < N_CLASSES; k++)
      for (int f = 0; f < N_FRAMES; f++)
        cls_mem[k][f] = {$urandom, $urandom};

    rst_n        = 1'b0;
    q_valid      = 1'b0;
    q_frame      = '0;
    result_ready = 1'b0;
`ifdef ASSOC_REJECT_EN
    reject_thr   = 8'd5;
`endif

    #12;
    check("rst_qready", q_ready, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_id", cls_frame_id, 0);
    check("rst_dist", result_dist, 0);
    check("rst_class", result_class, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_qready", q_ready, 1);

    // Exact copy of class 5.
    run_query(cls_vec(5), lat);
    check("c5_lat", lat, 27);
    check("c5_class", result_class, 5);
    check("c5_dist", result_dist, 0);
    check("c5_busy", busy, 1);
    consume();

    // Class 2 with seven flipped bits spread across the frames.
    qv = cls_vec(2);
    qv[0] = ~qv[0];
    qv[5] = ~qv[5];
    qv[63] = ~qv[63];
    qv[64+10] = ~qv[64+10];
    qv[64+20] = ~qv[64+20];
    qv[128+1] = ~qv[128+1];
    qv[128+40] = ~qv[128+40];
    run_query(qv, lat);
    check("c2_class", result_class, 2);
    check("c2_dist", result_dist, 7);
`ifdef ASSOC_REJECT_EN
    reject_thr = 8'd5;
    #1;
    check("rej_thr5", result_reject, 1);
    reject_thr = 8'd7;
    #1;
    check("rej_thr7", result_reject, 0);
`endif
    consume();

    // Classes 1 and 4 identical to the query; the lower index must win.
    qv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    set_cls(1, qv);
    set_cls(4, qv);
    run_query(qv, lat);
    check("tie_lat", lat, 27);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_class", result_class, 1);
      check("hold_dist", result_dist, 0);
      check("hold_qready", q_ready, 0);
      check("hold_id", cls_frame_id, 0);
      check("hold_idx", cls_frame_index, 0);
    end
    consume();

    // Reset in the middle of the search of class 4.
    send_frames(cls_vec(5));
    q_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (cls_frame_id == 3'd4) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_ccnt4", found, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", result_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_id", cls_frame_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_qready", q_ready, 1);
    check("mrst_valid2", result_valid, 0);

    run_query(cls_vec(5), lat);
    check("post_lat", lat, 27);
    check("post_class", result_class, 5);
    check("post_dist", result_dist, 0);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
